// File: rtl/sysid_boot_checker.sv
// Boot-time hardware/software compatibility check: reads system ID and build
// timestamp over Avalon-MM and reports whether they match the expected build.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start after reset
// REQ_ID  | read request on word 0, held until accepted
// WAIT_ID | waiting for word 0 readdatavalid
// REQ_TS  | read request on word 1, held until accepted
// WAIT_TS | waiting for word 1 readdatavalid
// CHECK   | compare captured words against expected values
// DONE    | status published, waiting for a new start
module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1360936698,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter int unsigned MAX_RETRIES        = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   input  logic        m_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts,
   output logic [3:0]  retry_count
);

   typedef enum logic [2:0] {
      IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK, DONE
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  MAX_R   = 4'(MAX_RETRIES);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  retry_q, retry_d;
   logic [31:0] cap_id_q, cap_id_d, cap_ts_q, cap_ts_d;
   logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
   logic        terr_q, terr_d, done_q, done_d;
   logic        read_q, read_d, addr_q, addr_d, busy_q, busy_d;
   logic        accept, expire, tmo;

   assign accept = (state_q == REQ_ID || state_q == REQ_TS) && !m_waitrequest;
   assign expire = (cnt_q == TO_LAST);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      retry_d  = retry_q;
      cap_id_d = cap_id_q;
      cap_ts_d = cap_ts_q;
      id_ok_d  = id_ok_q;
      ts_ok_d  = ts_ok_q;
      terr_d   = terr_q;
      done_d   = done_q;
      tmo      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = REQ_ID;
               cnt_d    = '0;
               retry_d  = '0;
               cap_id_d = '0;
               cap_ts_d = '0;
               id_ok_d  = 1'b0;
               ts_ok_d  = 1'b0;
               terr_d   = 1'b0;
               done_d   = 1'b0;
            end
         end
         REQ_ID, WAIT_ID: begin
            // readdatavalid counts only once the request has been accepted
            if ((state_q == WAIT_ID || accept) && m_readdatavalid) begin
               cap_id_d = m_readdata;
               state_d  = REQ_TS;
               cnt_d    = '0;
            end else if (expire) begin
               tmo = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (accept) state_d = WAIT_ID;
            end
         end
         REQ_TS, WAIT_TS: begin
            if ((state_q == WAIT_TS || accept) && m_readdatavalid) begin
               cap_ts_d = m_readdata;
               state_d  = CHECK;
            end else if (expire) begin
               tmo = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (accept) state_d = WAIT_TS;
            end
         end
         CHECK: begin
            id_ok_d = (cap_id_q == EXPECTED_ID);
            ts_ok_d = (cap_ts_q == EXPECTED_TIMESTAMP);
            done_d  = 1'b1;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      if (tmo) begin
         if (retry_q < MAX_R) begin
            retry_d  = retry_q + 4'd1;
            state_d  = REQ_ID;
            cnt_d    = '0;
            cap_id_d = '0;
            cap_ts_d = '0;
         end else begin
            terr_d  = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
         end
      end

      // bus and busy outputs are registered copies of the next-state decode
      read_d = (state_d == REQ_ID) || (state_d == REQ_TS);
      addr_d = (state_d == REQ_TS) || (state_d == WAIT_TS);
      busy_d = (state_d != IDLE) && (state_d != DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         retry_q  <= '0;
         cap_id_q <= '0;
         cap_ts_q <= '0;
         id_ok_q  <= 1'b0;
         ts_ok_q  <= 1'b0;
         terr_q   <= 1'b0;
         done_q   <= 1'b0;
         read_q   <= 1'b0;
         addr_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         retry_q  <= retry_d;
         cap_id_q <= cap_id_d;
         cap_ts_q <= cap_ts_d;
         id_ok_q  <= id_ok_d;
         ts_ok_q  <= ts_ok_d;
         terr_q   <= terr_d;
         done_q   <= done_d;
         read_q   <= read_d;
         addr_q   <= addr_d;
         busy_q   <= busy_d;
      end
   end

   assign m_read      = read_q;
   assign m_address   = addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout_err = terr_q;
   assign captured_id = cap_id_q;
   assign captured_ts = cap_ts_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker with a small configurable Avalon slave.
module tb_sysid_boot_checker;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        m_address, m_read, m_waitrequest, m_readdatavalid;
   logic [31:0] m_readdata;
   logic        busy, done, id_ok, ts_ok, timeout_err;
   logic [31:0] captured_id, captured_ts;
   logic [3:0]  retry_count;

   int n_cmp  = 0;
   int n_fail = 0;

   sysid_boot_checker #(
      .TIMEOUT_CYCLES(8),
      .MAX_RETRIES   (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .m_address      (m_address),
      .m_read         (m_read),
      .m_waitrequest  (m_waitrequest),
      .m_readdata     (m_readdata),
      .m_readdatavalid(m_readdatavalid),
      .busy           (busy),
      .done           (done),
      .id_ok          (id_ok),
      .ts_ok          (ts_ok),
      .timeout_err    (timeout_err),
      .captured_id    (captured_id),
      .captured_ts    (captured_ts),
      .retry_count    (retry_count)
   );

   always #5 clock = ~clock;

   // slave model: stall_n waitrequest cycles per read, then 0- or 1-cycle latency
   int          stall_n = 0;
   logic        lat0 = 1'b0;
   logic        mute = 1'b0;
   logic [31:0] mem_id = 32'd0;
   logic [31:0] mem_ts = 32'd1360936698;
   logic [3:0]  stall_cnt = '0;
   logic        pend_q = 1'b0;
   logic [31:0] pend_data = '0;
   int          acc_cnt = 0;
   logic        acc_log [64];
   int          stall_seen = 0;
   int          stall_viol = 0;
   logic        prev_stall = 1'b0;
   logic        prev_addr = 1'b0;
   logic        acc;

   assign m_waitrequest   = m_read && (int'(stall_cnt) < stall_n);
   assign acc             = m_read && !m_waitrequest;
   assign m_readdatavalid = mute ? 1'b0 : (lat0 ? acc : pend_q);
   assign m_readdata      = lat0 ? (m_address ? mem_ts : mem_id) : pend_data;

   always @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
         pend_q    <= 1'b0;
      end else begin
         if (m_read && m_waitrequest) stall_cnt <= stall_cnt + 4'd1;
         else if (acc)                stall_cnt <= '0;
         pend_q    <= acc;
         pend_data <= m_address ? mem_ts : mem_id;
      end
      if (acc) begin
         acc_log[acc_cnt % 64] <= m_address;
         acc_cnt <= acc_cnt + 1;
      end
      if (prev_stall && !reset && (!m_read || m_address != prev_addr))
         stall_viol <= stall_viol + 1;
      if (m_read && m_waitrequest) stall_seen <= stall_seen + 1;
      prev_stall <= m_read && m_waitrequest;
      prev_addr  <= m_address;
   end

   // Pulse start and count edges (the sampling edge is edge 1) until done.
   // A second start is raised after edge second_at when nonzero; -1 = no done.
   task automatic run_start(input int second_at, output int lat);
      @(negedge clock);
      start = 1'b1;
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clock);
         #1;
         start = (i == second_at);
         if (done && !start) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({m_read, m_address, busy, done, id_ok, ts_ok, timeout_err} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {m_read, m_address, busy, done, id_ok, ts_ok, timeout_err});
      end
      n_cmp++;
      if ({captured_id, captured_ts, retry_count} !== 68'd0) begin
         n_fail++;
         $display("FAIL reset_data: id %h ts %h retry %0d expected zeros",
                  captured_id, captured_ts, retry_count);
      end
   endtask

   task automatic test_pass_lat1();
      int lat, base;
      base = acc_cnt;
      run_start(0, lat);
      n_cmp++;
      if (lat !== 6) begin n_fail++; $display("FAIL pass_latency: got %0d expected 6", lat); end
      n_cmp++;
      if ({id_ok, ts_ok, timeout_err, busy} !== 4'b1100) begin
         n_fail++; $display("FAIL pass_status: got %b expected 1100", {id_ok, ts_ok, timeout_err, busy});
      end
      n_cmp++;
      if (retry_count !== 4'd0) begin n_fail++; $display("FAIL pass_retry: got %0d expected 0", retry_count); end
      n_cmp++;
      if (captured_ts !== 32'h511E3EFA) begin
         n_fail++; $display("FAIL pass_capts: got %h expected 511e3efa", captured_ts);
      end
      n_cmp++;
      if (acc_cnt - base !== 2) begin n_fail++; $display("FAIL pass_reads: got %0d expected 2", acc_cnt - base); end
   endtask

   task automatic test_zero_latency();
      int lat, base;
      lat0 = 1'b1;
      base = acc_cnt;
      run_start(0, lat);
      n_cmp++;
      if (lat !== 4) begin n_fail++; $display("FAIL zl_latency: got %0d expected 4", lat); end
      n_cmp++;
      if ({id_ok, ts_ok, timeout_err, retry_count} !== 7'b1100000) begin
         n_fail++; $display("FAIL zl_status: got %b expected 1100000", {id_ok, ts_ok, timeout_err, retry_count});
      end
      n_cmp++;
      if (acc_cnt - base !== 2) begin n_fail++; $display("FAIL zl_reads: got %0d expected 2", acc_cnt - base); end
      n_cmp++;
      if ({acc_log[base % 64], acc_log[(base + 1) % 64]} !== 2'b01) begin
         n_fail++; $display("FAIL zl_addrs: got %b expected 01", {acc_log[base % 64], acc_log[(base + 1) % 64]});
      end
      lat0 = 1'b0;
   endtask

   task automatic test_ts_mismatch();
      int lat;
      mem_ts = 32'd1360936699;
      run_start(0, lat);
      n_cmp++;
      if ({done, id_ok, ts_ok, timeout_err} !== 4'b1100) begin
         n_fail++; $display("FAIL tsmis_status: got %b expected 1100", {done, id_ok, ts_ok, timeout_err});
      end
      n_cmp++;
      if (captured_ts !== 32'd1360936699) begin
         n_fail++; $display("FAIL tsmis_capts: got %0d expected 1360936699", captured_ts);
      end
      mem_ts = 32'd1360936698;
   endtask

   task automatic test_id_mismatch();
      int lat;
      mem_id = 32'h0000_0005;
      run_start(0, lat);
      n_cmp++;
      if ({done, id_ok, ts_ok, timeout_err} !== 4'b1010) begin
         n_fail++; $display("FAIL idmis_status: got %b expected 1010", {done, id_ok, ts_ok, timeout_err});
      end
      n_cmp++;
      if (captured_id !== 32'h5) begin n_fail++; $display("FAIL idmis_capid: got %h expected 5", captured_id); end
      mem_id = 32'd0;
   endtask

   task automatic test_stall();
      int lat, v0, s0;
      stall_n = 3;
      v0 = stall_viol;
      s0 = stall_seen;
      run_start(0, lat);
      n_cmp++;
      if (lat !== 12) begin n_fail++; $display("FAIL stall_latency: got %0d expected 12", lat); end
      n_cmp++;
      if (stall_seen - s0 !== 6) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 6", stall_seen - s0); end
      n_cmp++;
      if (stall_viol - v0 !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", stall_viol - v0); end
      n_cmp++;
      if ({id_ok, ts_ok, timeout_err, retry_count} !== 7'b1100000) begin
         n_fail++; $display("FAIL stall_status: got %b expected 1100000", {id_ok, ts_ok, timeout_err, retry_count});
      end
      stall_n = 0;
   endtask

   task automatic test_timeout();
      int lat, base;
      mute = 1'b1;
      base = acc_cnt;
      run_start(0, lat);
      n_cmp++;
      if (lat !== 25) begin n_fail++; $display("FAIL tmo_latency: got %0d expected 25", lat); end
      n_cmp++;
      if ({done, timeout_err, id_ok, ts_ok, busy} !== 5'b11000) begin
         n_fail++; $display("FAIL tmo_status: got %b expected 11000", {done, timeout_err, id_ok, ts_ok, busy});
      end
      n_cmp++;
      if (retry_count !== 4'd2) begin n_fail++; $display("FAIL tmo_retry: got %0d expected 2", retry_count); end
      n_cmp++;
      if (acc_cnt - base !== 3) begin n_fail++; $display("FAIL tmo_attempts: got %0d expected 3", acc_cnt - base); end
      n_cmp++;
      if ({acc_log[base % 64], acc_log[(base + 1) % 64], acc_log[(base + 2) % 64]} !== 3'b000) begin
         n_fail++; $display("FAIL tmo_addrs: got %b expected 000",
                            {acc_log[base % 64], acc_log[(base + 1) % 64], acc_log[(base + 2) % 64]});
      end
      mute = 1'b0;
   endtask

   task automatic test_reset_midrun();
      int lat;
      @(negedge clock);
      start = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
      end
      n_cmp++;
      if ({busy, m_read, m_address} !== 3'b101) begin
         n_fail++; $display("FAIL rst_in_wait_ts: got %b expected 101", {busy, m_read, m_address});
      end
      reset = 1'b1;
      @(posedge clock);
      #1;
      n_cmp++;
      if ({m_read, m_address, busy, done, id_ok, ts_ok, timeout_err, retry_count} !== 11'd0 ||
          captured_id !== 32'd0 || captured_ts !== 32'd0) begin
         n_fail++; $display("FAIL rst_midrun: got %b ts %h expected all zero",
                            {m_read, m_address, busy, done, id_ok, ts_ok, timeout_err, retry_count}, captured_ts);
      end
      @(negedge clock);
      reset = 1'b0;
      run_start(0, lat);
      n_cmp++;
      if (lat !== 6 || {id_ok, ts_ok, timeout_err} !== 3'b110) begin
         n_fail++; $display("FAIL rst_rerun: lat %0d status %b expected 6 110", lat, {id_ok, ts_ok, timeout_err});
      end
   endtask

   task automatic test_double_start();
      int lat, base;
      base = acc_cnt;
      run_start(2, lat);
      n_cmp++;
      if (lat !== 6) begin n_fail++; $display("FAIL dbl_latency: got %0d expected 6", lat); end
      n_cmp++;
      if (acc_cnt - base !== 2) begin n_fail++; $display("FAIL dbl_reads: got %0d expected 2", acc_cnt - base); end
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if ({done, busy, id_ok, ts_ok} !== 4'b1011) begin
         n_fail++; $display("FAIL dbl_hold: got %b expected 1011", {done, busy, id_ok, ts_ok});
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_start(0, lat);
      n_cmp++;
      if (lat !== 6 || {id_ok, ts_ok} !== 2'b11) begin
         n_fail++; $display("FAIL b2b: lat %0d ok %b expected 6 11", lat, {id_ok, ts_ok});
      end
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      test_reset();
      @(negedge clock);
      reset = 1'b0;
      test_pass_lat1();
      test_zero_latency();
      test_ts_mismatch();
      test_id_mismatch();
      test_stall();
      test_timeout();
      test_reset_midrun();
      test_double_start();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
